// File: rtl/soccer_pkg.sv
// rtl/soccer_pkg.sv - shared soccer game types, field constants and helpers
package soccer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_KICKOFF    = 3'd1,
    ST_PLAY       = 3'd2,
    ST_GOAL_PAUSE = 3'd3,
    ST_GAME_OVER  = 3'd4
  } match_state_t;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_LEFT  = 2'b01,
    WIN_RIGHT = 2'b10,
    WIN_DRAW  = 2'b11
  } winner_t;

  // Field geometry shared by the match controller, player and ball modules.
  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int FIELD_LEFT_GOAL_X  = 40;
  localparam int FIELD_RIGHT_GOAL_X = 600;
  localparam int FIELD_CROSSBAR_Y   = 380;

  // Score increment that sticks at the 4-bit ceiling.
  function automatic logic [3:0] score_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  function automatic winner_t decide_winner(input logic [3:0] l, input logic [3:0] r);
    if (l > r) return WIN_LEFT;
    if (r > l) return WIN_RIGHT;
    return WIN_DRAW;
  endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// rtl/sec_tick_gen.sv - sub-second frame counter producing a once-per-second tick
module sec_tick_gen #(
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic frame_clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic sec_tick
);

  localparam int W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [W-1:0] LAST = W'(FRAMES_PER_SEC - 1);

  logic [W-1:0] frame_cnt;

  // Count frames within the current second; clear restarts the second on a phase change.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)
      frame_cnt <= '0;
    else if (clear)
      frame_cnt <= '0;
    else if (enable)
      frame_cnt <= (frame_cnt == LAST) ? '0 : frame_cnt + W'(1);
  end

  assign sec_tick = enable && (frame_cnt == LAST);

endmodule

// File: rtl/match_controller.sv
// rtl/match_controller.sv - match phase sequencer, goal detection, scores and match clock
module match_controller import soccer_pkg::*; #(
  parameter int FRAMES_PER_SEC    = 60,
  parameter int KICKOFF_SEC       = 3,
  parameter int GOAL_PAUSE_FRAMES = 120,
  parameter int MATCH_SEC         = 90,
  parameter int WIN_SCORE         = 5,
  parameter int LEFT_GOAL_X       = FIELD_LEFT_GOAL_X,
  parameter int RIGHT_GOAL_X      = FIELD_RIGHT_GOAL_X,
  parameter int GOAL_Y_TOP        = FIELD_CROSSBAR_Y
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       StartBtn,
  input  logic [9:0] BallX,
  input  logic [9:0] BallY,
  output logic       AllowInput,
  output logic       EntityReset,
  output logic [3:0] ScoreL,
  output logic [3:0] ScoreR,
  output logic [1:0] Countdown,
  output logic [6:0] TimeLeft,
  output logic [2:0] State,
  output logic [1:0] Winner
);

  localparam int PW = (GOAL_PAUSE_FRAMES > 1) ? $clog2(GOAL_PAUSE_FRAMES) : 1;
  localparam logic [PW-1:0] PAUSE_LAST = PW'(GOAL_PAUSE_FRAMES - 1);

  match_state_t state, state_n;
  winner_t      winner_q, winner_n;
  logic [3:0]   score_l_n, score_r_n;
  logic [1:0]   countdown_n;
  logic [6:0]   time_n;
  logic         allow_n, ent_reset_n;
  logic         start_q, start_edge;
  logic [PW-1:0] pause_cnt;
  logic         sec_tick;
  logic         left_goal, right_goal;

  assign start_edge = StartBtn & ~start_q;
  assign left_goal  = (BallX <= 10'(LEFT_GOAL_X))  && (BallY >= 10'(GOAL_Y_TOP));
  assign right_goal = (BallX >= 10'(RIGHT_GOAL_X)) && (BallY >= 10'(GOAL_Y_TOP));
  assign State  = state;
  assign Winner = winner_q;

  sec_tick_gen #(.FRAMES_PER_SEC(FRAMES_PER_SEC)) u_sec_tick (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .clear     (state_n != state),
    .enable    ((state == ST_KICKOFF) || (state == ST_PLAY)),
    .sec_tick  (sec_tick)
  );

  // Register phase, scores, clock and every output; start_q resets high to ignore a held button.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state       <= ST_IDLE;
      ScoreL      <= 4'd0;
      ScoreR      <= 4'd0;
      TimeLeft    <= 7'(MATCH_SEC);
      Countdown   <= 2'd0;
      AllowInput  <= 1'b0;
      EntityReset <= 1'b0;
      winner_q    <= WIN_NONE;
      start_q     <= 1'b1;
    end else begin
      state       <= state_n;
      ScoreL      <= score_l_n;
      ScoreR      <= score_r_n;
      TimeLeft    <= time_n;
      Countdown   <= countdown_n;
      AllowInput  <= allow_n;
      EntityReset <= ent_reset_n;
      winner_q    <= winner_n;
      start_q     <= StartBtn;
    end
  end

  // Goal-pause frame counter, restarted whenever a phase is entered.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)
      pause_cnt <= '0;
    else if (state_n != state)
      pause_cnt <= '0;
    else if (state == ST_GOAL_PAUSE)
      pause_cnt <= pause_cnt + PW'(1);
  end

  // Next phase and next register values; a goal on the final second still wins over timeout.
  always_comb begin
    state_n     = state;
    score_l_n   = ScoreL;
    score_r_n   = ScoreR;
    time_n      = TimeLeft;
    countdown_n = Countdown;
    winner_n    = winner_q;
    ent_reset_n = 1'b0;
    case (state)
      ST_IDLE, ST_GAME_OVER: begin
        if (start_edge) begin
          state_n     = ST_KICKOFF;
          ent_reset_n = 1'b1;
          score_l_n   = 4'd0;
          score_r_n   = 4'd0;
          time_n      = 7'(MATCH_SEC);
          countdown_n = 2'(KICKOFF_SEC);
          winner_n    = WIN_NONE;
        end
      end
      ST_KICKOFF: begin
        if (sec_tick) begin
          if (Countdown > 2'd1) begin
            countdown_n = Countdown - 2'd1;
          end else begin
            countdown_n = 2'd0;
            state_n     = ST_PLAY;
          end
        end
      end
      ST_PLAY: begin
        if (sec_tick && (TimeLeft != 7'd0))
          time_n = TimeLeft - 7'd1;
        if (left_goal) begin
          score_r_n = score_inc(ScoreR);
          state_n   = ST_GOAL_PAUSE;
        end else if (right_goal) begin
          score_l_n = score_inc(ScoreL);
          state_n   = ST_GOAL_PAUSE;
        end else if (sec_tick && (TimeLeft == 7'd1)) begin
          state_n = ST_GAME_OVER;
        end
      end
      ST_GOAL_PAUSE: begin
        if (pause_cnt == PAUSE_LAST) begin
          if ((ScoreL >= 4'(WIN_SCORE)) || (ScoreR >= 4'(WIN_SCORE)) || (TimeLeft == 7'd0)) begin
            state_n = ST_GAME_OVER;
          end else begin
            state_n     = ST_KICKOFF;
            ent_reset_n = 1'b1;
            countdown_n = 2'(KICKOFF_SEC);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if ((state_n == ST_GAME_OVER) && (state != ST_GAME_OVER))
      winner_n = decide_winner(score_l_n, score_r_n);
    allow_n = (state_n == ST_PLAY);
  end

endmodule

// File: tb/tb_match_controller.sv
// tb/tb_match_controller.sv - randomized self-checking bench for match_controller
module tb_match_controller;

  localparam int FPS  = 60;
  localparam int KSEC = 3;
  localparam int GPF  = 120;
  localparam int MSEC = 90;
  localparam int WINS = 5;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       StartBtn = 1'b1;
  logic [9:0] BallX = 10'd300;
  logic [9:0] BallY = 10'd200;
  logic       AllowInput, EntityReset;
  logic [3:0] ScoreL, ScoreR;
  logic [1:0] Countdown;
  logic [6:0] TimeLeft;
  logic [2:0] State;
  logic [1:0] Winner;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: phase number, cycles spent in the phase, and the visible values.
  int m_phase, m_in_phase, m_time, m_sl, m_sr, m_cd, m_win;
  bit m_allow, m_er, m_sq;

  match_controller dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .StartBtn    (StartBtn),
    .BallX       (BallX),
    .BallY       (BallY),
    .AllowInput  (AllowInput),
    .EntityReset (EntityReset),
    .ScoreL      (ScoreL),
    .ScoreR      (ScoreR),
    .Countdown   (Countdown),
    .TimeLeft    (TimeLeft),
    .State       (State),
    .Winner      (Winner)
  );

  always #5 frame_clk = ~frame_clk;

  logic [23:0] dut_vec;
  assign dut_vec = {State, ScoreL, ScoreR, Countdown, TimeLeft, Winner, AllowInput, EntityReset};

  localparam logic [23:0] RESET_VEC = {3'd0, 4'd0, 4'd0, 2'd0, 7'd90, 2'b00, 1'b0, 1'b0};

  function automatic logic [23:0] exp_vec();
    return {3'(m_phase), 4'(m_sl), 4'(m_sr), 2'(m_cd), 7'(m_time), 2'(m_win), m_allow, m_er};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_in_phase = 0; m_time = MSEC; m_sl = 0; m_sr = 0;
    m_cd = 0; m_win = 0; m_allow = 0; m_er = 0; m_sq = 1;
  endtask

  task automatic model_update();
    int  np;
    bit  se, tick, lg, rg;
    np   = m_phase;
    se   = StartBtn && !m_sq;
    tick = (m_in_phase % FPS) == FPS - 1;
    m_er = 0;
    case (m_phase)
      0, 4: if (se) begin
        np = 1; m_sl = 0; m_sr = 0; m_time = MSEC; m_cd = KSEC; m_win = 0; m_er = 1;
      end
      1: begin
        if (m_in_phase + 1 == KSEC * FPS) begin np = 2; m_cd = 0; end
        else m_cd = KSEC - (m_in_phase + 1) / FPS;
      end
      2: begin
        lg = (BallX <= 40) && (BallY >= 380);
        rg = (BallX >= 600) && (BallY >= 380);
        if (tick && m_time > 0) m_time = m_time - 1;
        if (lg) m_sr = (m_sr < 15) ? m_sr + 1 : 15;
        if (rg) m_sl = (m_sl < 15) ? m_sl + 1 : 15;
        if (lg || rg) np = 3;
        else if (tick && m_time == 0) np = 4;
      end
      3: if (m_in_phase + 1 == GPF) begin
        if (m_sl >= WINS || m_sr >= WINS || m_time == 0) np = 4;
        else begin np = 1; m_cd = KSEC; m_er = 1; end
      end
      default: np = 0;
    endcase
    if (np == 4 && m_phase != 4) m_win = (m_sl > m_sr) ? 1 : (m_sr > m_sl) ? 2 : 3;
    m_in_phase = (np != m_phase) ? 0 : m_in_phase + 1;
    m_phase = np;
    m_allow = (np == 2);
    m_sq = StartBtn;
  endtask

  task automatic step();
    @(posedge frame_clk);
    if (Reset) model_reset();
    else model_update();
    #1;
  endtask

  task automatic ball_safe();
    if ($urandom_range(0, 1) == 1) begin
      BallX = 10'($urandom_range(41, 599)); BallY = 10'($urandom_range(0, 1023));
    end else begin
      BallX = 10'($urandom_range(0, 1023)); BallY = 10'($urandom_range(0, 379));
    end
  endtask

  task automatic ball_any();
    BallX = 10'($urandom_range(0, 1023)); BallY = 10'($urandom_range(0, 1023));
  endtask

  task automatic test_reset();
    int n;
    model_reset();
    Reset = 1; StartBtn = 1;
    repeat (3) step();
    n_vec++;
    if (dut_vec !== RESET_VEC) begin n_err++; $display("FAIL reset_vals: got %h want %h", dut_vec, RESET_VEC); end
    Reset = 0;
    for (int i = 0; i < 5; i++) begin
      ball_any(); step(); n_vec++;
      if (State !== 3'd0) begin n_err++; $display("FAIL held_start: State=%0d want 0", State); end
    end
    StartBtn = 0; step();
    StartBtn = 1; step(); n_vec++;
    if ({State, EntityReset, Countdown} !== {3'd1, 1'b1, 2'd3}) begin
      n_err++; $display("FAIL start_press: State=%0d ER=%0b CD=%0d want 1 1 3", State, EntityReset, Countdown);
    end
    StartBtn = 0;
    n = 0;
    while (n < 400 && State !== 3'd2) begin
      ball_any(); step(); n++; n_vec++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL kickoff_cycle: got %h want %h", dut_vec, exp_vec()); end
    end
    n_vec++;
    if (n !== KSEC * FPS || AllowInput !== 1'b1) begin
      n_err++; $display("FAIL kickoff_len: cycles=%0d allow=%0b want %0d 1", n, AllowInput, KSEC * FPS);
    end
  endtask

  task automatic test_left_goal();
    int d;
    d = $urandom_range(10, 50);
    for (int i = 0; i < d; i++) begin
      ball_safe(); step(); n_vec++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL play_idle: got %h want %h", dut_vec, exp_vec()); end
    end
    BallX = 10'd30; BallY = 10'd400; step(); n_vec++;
    if ({ScoreR, State, AllowInput} !== {4'd1, 3'd3, 1'b0}) begin
      n_err++; $display("FAIL left_goal: ScoreR=%0d State=%0d allow=%0b want 1 3 0", ScoreR, State, AllowInput);
    end
    for (int i = 0; i < GPF - 1; i++) begin
      ball_any(); step(); n_vec++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL pause_cycle: got %h want %h", dut_vec, exp_vec()); end
    end
    step(); n_vec++;
    if ({EntityReset, State, Countdown} !== {1'b1, 3'd1, 2'd3}) begin
      n_err++; $display("FAIL pause_exit: ER=%0b State=%0d CD=%0d want 1 1 3", EntityReset, State, Countdown);
    end
  endtask

  task automatic test_near_miss();
    for (int i = 0; i < 400 && State !== 3'd2; i++) begin
      ball_any(); step(); n_vec++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL nm_wait: got %h want %h", dut_vec, exp_vec()); end
    end
    BallX = 10'd30; BallY = 10'd300; step(); n_vec++;
    if ({State, ScoreL, ScoreR} !== {3'd2, 4'd0, 4'd1}) begin
      n_err++; $display("FAIL over_bar: State=%0d L=%0d R=%0d want 2 0 1", State, ScoreL, ScoreR);
    end
    BallX = 10'd620; BallY = 10'd379; step(); n_vec++;
    if ({State, ScoreL, ScoreR} !== {3'd2, 4'd0, 4'd1}) begin
      n_err++; $display("FAIL right_bar: State=%0d L=%0d R=%0d want 2 0 1", State, ScoreL, ScoreR);
    end
    for (int i = 0; i < 200; i++) begin
      ball_safe(); StartBtn = 1'($urandom_range(0, 1)); step(); n_vec++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL near_miss: got %h want %h", dut_vec, exp_vec()); end
    end
    StartBtn = 0;
  endtask

  task automatic test_win();
    for (int g = 0; g < WINS; g++) begin
      for (int i = 0; i < 400 && State !== 3'd2; i++) begin
        ball_any(); step(); n_vec++;
        if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL win_wait: got %h want %h", dut_vec, exp_vec()); end
      end
      for (int i = 0; i < int'($urandom_range(1, 30)); i++) begin
        ball_safe(); step(); n_vec++;
        if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL win_play: got %h want %h", dut_vec, exp_vec()); end
      end
      BallX = 10'd610; BallY = 10'd420; step(); n_vec++;
      if ({ScoreL, State} !== {4'(g + 1), 3'd3}) begin
        n_err++; $display("FAIL right_goal: ScoreL=%0d State=%0d want %0d 3", ScoreL, State, g + 1);
      end
      for (int i = 0; i < GPF; i++) begin
        ball_any(); step(); n_vec++;
        if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL win_pause: got %h want %h", dut_vec, exp_vec()); end
      end
    end
    n_vec++;
    if ({State, Winner, EntityReset} !== {3'd4, 2'b01, 1'b0}) begin
      n_err++; $display("FAIL win_over: State=%0d Winner=%0d ER=%0b want 4 1 0", State, Winner, EntityReset);
    end
  endtask

  task automatic test_timeout();
    int n;
    StartBtn = 0; step();
    StartBtn = 1; step(); n_vec++;
    if ({State, ScoreL, ScoreR, TimeLeft, Winner} !== {3'd1, 4'd0, 4'd0, 7'd90, 2'b00}) begin
      n_err++; $display("FAIL restart: got %h want State 1 clear scores", dut_vec);
    end
    StartBtn = 0;
    for (int i = 0; i < 400 && State !== 3'd2; i++) begin ball_any(); step(); end
    n = 0;
    while (n < 6000 && State === 3'd2) begin
      ball_safe(); step(); n++; n_vec++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL time_run: got %h want %h", dut_vec, exp_vec()); end
    end
    n_vec++;
    if (n !== MSEC * FPS || {State, Winner, TimeLeft} !== {3'd4, 2'b11, 7'd0}) begin
      n_err++; $display("FAIL timeout: cycles=%0d State=%0d Winner=%0d T=%0d want %0d 4 3 0", n, State, Winner, TimeLeft, MSEC * FPS);
    end
    StartBtn = 1; step(); StartBtn = 0;
    for (int i = 0; i < 400 && State !== 3'd2; i++) begin ball_any(); step(); end
    n = 0;
    while (n < 6000 && !(m_phase == 2 && m_time == 1 && (m_in_phase % FPS) == FPS - 1)) begin
      ball_safe(); step(); n++;
    end
    BallX = 10'd30; BallY = 10'd400; step(); n_vec++;
    if ({State, ScoreR, TimeLeft} !== {3'd3, 4'd1, 7'd0}) begin
      n_err++; $display("FAIL last_tick_goal: State=%0d R=%0d T=%0d want 3 1 0", State, ScoreR, TimeLeft);
    end
    for (int i = 0; i < GPF; i++) begin ball_any(); step(); end
    n_vec++;
    if ({State, Winner} !== {3'd4, 2'b10}) begin
      n_err++; $display("FAIL last_tick_over: State=%0d Winner=%0d want 4 2", State, Winner);
    end
  endtask

  task automatic test_reset_mid();
    StartBtn = 1; step();
    for (int i = 0; i < 400 && State !== 3'd2; i++) begin ball_any(); step(); end
    BallX = 10'd30; BallY = 10'd400; step();
    for (int i = 0; i < int'($urandom_range(5, 100)); i++) begin ball_any(); step(); end
    n_vec++;
    if (State !== 3'd3) begin n_err++; $display("FAIL mid_setup: State=%0d want 3", State); end
    #2 Reset = 1;
    #1 n_vec++;
    if (dut_vec !== RESET_VEC) begin n_err++; $display("FAIL reset_mid: got %h want %h", dut_vec, RESET_VEC); end
    step(); step();
    Reset = 0;
    for (int i = 0; i < 4; i++) begin
      step(); n_vec++;
      if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL post_reset: got %h want %h", dut_vec, exp_vec()); end
    end
    StartBtn = 0;
  endtask

  initial begin
    test_reset();
    test_left_goal();
    test_near_miss();
    test_win();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
